layer_dump: RTL and testbench

- Host-side reader for the convolution layer memories: after the convolution engine drops busy, this block drains layer results and streams them out to a checker or host port.
- Layers covered: L0 (64x64 results, csel=3'b001) and L1 (32x32 max-pooled results, csel=3'b011).
- Reads through the crd/caddr_rd/csel/cdata_rd port, the read side of the engine's cwr/caddr_wr/csel write path.
- Emits words on a valid/ready stream, tagged with layer, address and last.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/dump_skid_fifo.sv | 43 ++++
 rtl/layer_dump.sv | 141 ++++++++++++++
 tb/tb_layer_dump.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, memory-select encodings, dump FSM states and the tagged stream word.
// Used by the layer dump reader and its skid FIFO.
package conv_pkg;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 20;
  localparam int L0_WORDS = 4096;
  localparam int L1_WORDS = 1024;

  localparam logic [ADDR_W-1:0] L0_LAST = ADDR_W'(L0_WORDS - 1);
  localparam logic [ADDR_W-1:0] L1_LAST = ADDR_W'(L1_WORDS - 1);

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {IDLE, RD_L0, RD_L1, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              layer;
    logic              last;
  } dump_word_t;
endpackage

// File: rtl/dump_skid_fifo.sv
// 2-entry register FIFO; data visible at dout the cycle after push.
// Push while full and pop while empty are ignored; the reader's issue rule never overfills it.
module dump_skid_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/layer_dump.sv
// Drains L0/L1 layer memories onto a tagged valid/ready stream; first word 2 cycles after start, then 1/cycle.
// Stalls hold the head stable; reads pause once FIFO + in-flight reach 2. LAYER_DUMP_CHKSUM_EN adds a chksum port.
module layer_dump
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        layer_mask,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [2:0]        csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_layer,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
`ifdef LAYER_DUMP_CHKSUM_EN
  ,
  output logic [31:0]       chksum
`endif
);
  state_t            state, state_nx;
  logic [1:0]        mask_q, mask_eff;
  logic [ADDR_W-1:0] rd_cnt, cnt;
  logic              last_rd;
  logic              inflight, in_layer, in_last;
  logic [ADDR_W-1:0] in_addr;
  logic              start_ok, rd_act, rd_l1, layer_end, final_layer, issue;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]        fifo_count, count_nx;
  dump_word_t        fifo_dout, byp_word, head;

  assign start_ok    = start && (state == IDLE);
  assign mask_eff    = (state == IDLE) ? layer_mask : mask_q;
  // The accepted-start cycle already issues address 0 so the first word lands two cycles after start.
  assign rd_act      = (state == RD_L0) || (state == RD_L1) || (start_ok && (layer_mask != 2'b00));
  assign rd_l1       = (state == RD_L1) || ((state == IDLE) && (layer_mask == 2'b10));
  assign cnt         = (state == IDLE) ? '0 : rd_cnt;
  assign layer_end   = rd_l1 ? (cnt == L1_LAST) : (cnt == L0_LAST);
  assign final_layer = rd_l1 || !mask_eff[1];

  // Empty FIFO with data arriving and a ready sink bypasses straight to the output.
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = inflight && !(fifo_empty && out_ready);
  assign count_nx  = fifo_count + 2'(fifo_push) - 2'(fifo_pop);
  // crd is registered, so predict next cycle's FIFO count; current crd becomes next cycle's inflight.
  assign issue     = rd_act && ((3'(count_nx) + 3'(crd)) < 3'd2);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start_ok) begin
        if (layer_mask[0])      state_nx = RD_L0;
        else if (layer_mask[1]) state_nx = RD_L1;
        else                    state_nx = FIN;
      end
      RD_L0:   if (issue && layer_end) state_nx = mask_q[1] ? RD_L1 : DRAIN;
      RD_L1:   if (issue && layer_end) state_nx = DRAIN;
      DRAIN:   if (fifo_empty && !inflight && !crd) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RD_L0) || (state == RD_L1) || (state == DRAIN);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= CSEL_NONE;
      rd_cnt   <= '0;
      mask_q   <= 2'b00;
      last_rd  <= 1'b0;
      inflight <= 1'b0;
      in_addr  <= '0;
      in_layer <= 1'b0;
      in_last  <= 1'b0;
    end else begin
      crd <= issue;
      if (start_ok) mask_q <= layer_mask;
      if (issue) begin
        caddr_rd <= cnt;
        csel     <= rd_l1 ? CSEL_L1 : CSEL_L0;
        last_rd  <= final_layer && layer_end;
        rd_cnt   <= layer_end ? '0 : cnt + ADDR_W'(1);
      end else begin
        csel <= (state_nx == RD_L0) ? CSEL_L0 : (state_nx == RD_L1) ? CSEL_L1 : CSEL_NONE;
      end
      inflight <= crd;
      in_addr  <= caddr_rd;
      in_layer <= (csel == CSEL_L1);
      in_last  <= last_rd;
    end
  end

  always_comb begin
    byp_word = '{data: cdata_rd, addr: in_addr, layer: in_layer, last: in_last};
    if (!fifo_empty)   head = fifo_dout;
    else if (inflight) head = byp_word;
    else               head = '0;
    out_valid = !fifo_empty || inflight;
    out_data  = head.data;
    out_addr  = head.addr;
    out_layer = head.layer;
    out_last  = head.last;
  end

  dump_skid_fifo #(.W($bits(dump_word_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (byp_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef LAYER_DUMP_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset)                      chksum <= '0;
    else if (start_ok)               chksum <= '0;
    else if (out_valid && out_ready) chksum <= chksum + 32'(out_data);
  end
`endif
endmodule

// File: tb/tb_layer_dump.sv
// Directed bench for layer_dump: memory responder, per-scenario tasks, stream order/stall/issue-limit tracking.
module tb_layer_dump;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [1:0]  layer_mask;
  logic        busy, done, crd, out_valid, out_layer, out_last;
  logic [11:0] caddr_rd, out_addr;
  logic [2:0]  csel;
  logic [19:0] cdata_rd, out_data;
`ifdef LAYER_DUMP_CHKSUM_EN
  logic [31:0] chksum;
`endif

  int errors = 0;
  int checks = 0;
  int l1_mode = 0;

  int n_xfer, n_bad, n_stall, n_ovf, n_rd_l0, n_rd_l1, n_rd_bad, n_last;
  int n_busy_gap, n_busy_hi, first_v, first_x, last_x, done_cyc, first_rd_addr;
  logic done_after, busy_after, busy_at_done;

  always #5 clk = ~clk;

  layer_dump dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .layer_mask (layer_mask),
    .busy       (busy),
    .done       (done),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .csel       (csel),
    .cdata_rd   (cdata_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_layer  (out_layer),
    .out_addr   (out_addr),
    .out_last   (out_last)
`ifdef LAYER_DUMP_CHKSUM_EN
    ,
    .chksum     (chksum)
`endif
  );

  function automatic logic [19:0] model(input logic layer, input logic [11:0] a);
    if (!layer)            return {8'h00, a};
    else if (l1_mode == 1) return 20'hFFFFF;
    else                   return {8'hA5, a};
  endfunction

  // Layer memory: data appears exactly one cycle after a read strobe.
  always @(posedge clk) begin
    if (crd && csel == 3'b001)      cdata_rd <= model(1'b0, caddr_rd);
    else if (crd && csel == 3'b011) cdata_rd <= model(1'b1, caddr_rd);
    else                            cdata_rd <= 20'h0BAD0;
  end

  task automatic run_dump(input logic [1:0] mask, input int rdy_pct, input int restart_cyc);
    int total, idx, outst;
    logic xfer, pv, pr, pl, plast, exp_layer;
    logic [19:0] pd;
    logic [11:0] pa, exp_addr;
    total = (mask[0] ? 4096 : 0) + (mask[1] ? 1024 : 0);
    n_xfer = 0; n_bad = 0; n_stall = 0; n_ovf = 0; n_rd_l0 = 0; n_rd_l1 = 0; n_rd_bad = 0;
    n_last = 0; n_busy_gap = 0; n_busy_hi = 0; first_v = -1; first_x = -1; last_x = -1;
    done_cyc = -1; first_rd_addr = -1; busy_at_done = 1'b1;
    idx = 0; outst = 0; pv = 0; pr = 0; pd = '0; pa = '0; pl = 0; plast = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start      = (cyc == 0) || (cyc == restart_cyc);
      layer_mask = (cyc == 0) ? mask : 2'b11;
      out_ready  = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (crd) begin
        if (outst >= 2) n_ovf++;
        if (first_rd_addr < 0) first_rd_addr = int'(caddr_rd);
        if (csel == 3'b001)      n_rd_l0++;
        else if (csel == 3'b011) n_rd_l1++;
        else                     n_rd_bad++;
      end
      if (pv && !pr && (!out_valid || out_data !== pd || out_addr !== pa ||
                        out_layer !== pl || out_last !== plast)) n_stall++;
      if (out_valid && first_v < 0) first_v = cyc;
      xfer = out_valid && out_ready;
      if (xfer) begin
        exp_layer = !(mask[0] && idx < 4096);
        exp_addr  = (exp_layer && mask[0]) ? 12'(idx - 4096) : 12'(idx);
        if (idx >= total || out_layer !== exp_layer || out_addr !== exp_addr ||
            out_data !== model(exp_layer, exp_addr) || out_last !== (idx == total - 1)) n_bad++;
        if (out_last) n_last++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_xfer++;
        idx++;
      end
      if (busy) n_busy_hi++;
      else if (cyc > 0 && !done) n_busy_gap++;
      outst = outst + int'(crd) - int'(xfer);
      pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_layer; plast = out_last;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; layer_mask = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({busy, done, crd} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: busy/done/crd=%b expected 000", {busy, done, crd}); end
    checks++; if ({caddr_rd, csel} !== 15'd0) begin errors++; $display("FAIL reset_rd: caddr_rd=%0d csel=%b expected 0/000", caddr_rd, csel); end
    checks++; if ({out_valid, out_data, out_layer, out_addr, out_last} !== 35'd0) begin errors++;
      $display("FAIL reset_out: valid=%b data=%h layer=%b addr=%0d last=%b expected all 0", out_valid, out_data, out_layer, out_addr, out_last); end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_dump;
    logic hit;
    hit = 1'b0;
    @(negedge clk); start = 1'b1; layer_mask = 2'b01; out_ready = 1'b1;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (crd && caddr_rd == 12'd100) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach: read of address 100 seen=%b expected 1", hit); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if ({busy, done, crd, csel, caddr_rd} !== 18'd0) begin errors++;
      $display("FAIL mid_reset_rd: busy=%b done=%b crd=%b csel=%b caddr=%0d expected all 0", busy, done, crd, csel, caddr_rd); end
    checks++; if ({out_valid, out_data, out_layer, out_addr, out_last} !== 35'd0) begin errors++;
      $display("FAIL mid_reset_out: valid=%b data=%h addr=%0d expected all 0", out_valid, out_data, out_addr); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_l0_only;
    run_dump(2'b01, 100, -1);
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL l0_done: no done within bound"); end
    checks++; if (n_xfer !== 4096) begin errors++; $display("FAIL l0_count: got %0d expected 4096", n_xfer); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL l0_words: %0d wrong words expected 0", n_bad); end
    checks++; if (n_last !== 1) begin errors++; $display("FAIL l0_last: %0d last flags expected 1", n_last); end
    checks++; if (first_rd_addr !== 0) begin errors++; $display("FAIL l0_first_rd: addr %0d expected 0", first_rd_addr); end
    checks++; if (n_rd_l1 !== 0 || n_rd_bad !== 0) begin errors++; $display("FAIL l0_csel: l1 reads %0d bad %0d expected 0", n_rd_l1, n_rd_bad); end
    checks++; if (first_v !== 2) begin errors++; $display("FAIL l0_latency: first valid at %0d expected 2", first_v); end
    checks++; if (last_x - first_x !== 4095) begin errors++; $display("FAIL l0_rate: span %0d expected 4095", last_x - first_x); end
    checks++; if (n_busy_gap !== 0 || busy_at_done !== 1'b0) begin errors++; $display("FAIL l0_busy: gaps %0d busy_at_done %b expected 0/0", n_busy_gap, busy_at_done); end
    checks++; if ({done_after, busy_after} !== 2'b00) begin errors++; $display("FAIL l0_after: done/busy=%b expected 00", {done_after, busy_after}); end
  endtask

  task automatic test_both_layers;
    run_dump(2'b11, 100, -1);
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL both_done: no done within bound"); end
    checks++; if (n_xfer !== 5120) begin errors++; $display("FAIL both_count: got %0d expected 5120", n_xfer); end
    checks++; if (n_bad !== 0 || n_last !== 1) begin errors++; $display("FAIL both_words: bad %0d last %0d expected 0/1", n_bad, n_last); end
    checks++; if (n_rd_l0 !== 4096 || n_rd_l1 !== 1024) begin errors++; $display("FAIL both_reads: l0 %0d l1 %0d expected 4096/1024", n_rd_l0, n_rd_l1); end
    checks++; if (last_x - first_x !== 5119) begin errors++; $display("FAIL both_rate: span %0d expected 5119", last_x - first_x); end
  endtask

  task automatic test_random_stall;
    run_dump(2'b10, 50, -1);
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL stall_done: no done within bound"); end
    checks++; if (n_xfer !== 1024 || n_bad !== 0) begin errors++; $display("FAIL stall_words: count %0d bad %0d expected 1024/0", n_xfer, n_bad); end
    checks++; if (n_stall !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable stalls expected 0", n_stall); end
    checks++; if (n_ovf !== 0) begin errors++; $display("FAIL stall_issue: %0d reads with 2 outstanding expected 0", n_ovf); end
    checks++; if (n_rd_l0 !== 0 || n_rd_l1 !== 1024) begin errors++; $display("FAIL stall_reads: l0 %0d l1 %0d expected 0/1024", n_rd_l0, n_rd_l1); end
    checks++; if (n_last !== 1) begin errors++; $display("FAIL stall_last: %0d last flags expected 1", n_last); end
  endtask

  task automatic test_empty_mask;
    run_dump(2'b00, 100, -1);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL empty_done: done at %0d expected 1", done_cyc); end
    checks++; if (n_rd_l0 + n_rd_l1 + n_rd_bad !== 0 || n_xfer !== 0) begin errors++;
      $display("FAIL empty_reads: reads %0d words %0d expected 0/0", n_rd_l0 + n_rd_l1 + n_rd_bad, n_xfer); end
    checks++; if (n_busy_hi !== 0 || done_after !== 1'b0) begin errors++; $display("FAIL empty_busy: busy cycles %0d done_after %b expected 0/0", n_busy_hi, done_after); end
  endtask

  task automatic test_back_to_back;
    run_dump(2'b10, 100, 50);
    checks++; if (n_xfer !== 1024 || n_bad !== 0) begin errors++; $display("FAIL restart_words: count %0d bad %0d expected 1024/0", n_xfer, n_bad); end
    checks++; if (n_rd_l0 !== 0) begin errors++; $display("FAIL restart_mask: l0 reads %0d expected 0", n_rd_l0); end
  endtask

`ifdef LAYER_DUMP_CHKSUM_EN
  task automatic test_chksum;
    l1_mode = 1;
    run_dump(2'b10, 100, -1);
    checks++; if (chksum !== 32'h3FFFFC00) begin errors++; $display("FAIL chksum: got %h expected 3ffffc00", chksum); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL chksum_words: bad %0d expected 0", n_bad); end
    l1_mode = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid_dump;
    test_l0_only;
    test_both_layers;
    test_random_stall;
    test_empty_mask;
    test_back_to_back;
`ifdef LAYER_DUMP_CHKSUM_EN
    test_chksum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
